fir_mac_pipe: RTL and testbench
===============================

Name: fir_mac_pipe

Overview:
Parametrised pipelined multiply-accumulate for FIR datapaths: a NUM_STAGE-deep multiplier followed by one accumulator stage and an output saturate/shift stage. Each input pair carries valid/first/last sideband. One dout_valid pulse is emitted per accumulation frame. It generalises the fixed 32x8 signed clock-enabled multiplier with configurable widths, signedness, depth, accumulation and saturation.

Parameters:
DIN0_WIDTH, 32, width of din0 (sample)
DIN1_WIDTH, 8, width of din1 (coefficient)
ACC_WIDTH, 40, accumulator width; must be >= DIN0_WIDTH+DIN1_WIDTH
DOUT_WIDTH, 32, result width
NUM_STAGE, 2, multiplier pipeline registers; must be >= 1
SIGNED0, 1, 1 = din0 two's complement, 0 = unsigned
SIGNED1, 1, 1 = din1 two's complement, 0 = unsigned
SAT_EN, 1, 1 = clamp result to DOUT range, 0 = truncate
SHIFT, 0, arithmetic right shift applied to accumulator before narrowing (0..ACC_WIDTH-1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
ce  in  1  clock enable; low freezes every register
in_valid  in  1  din0/din1/acc_first/acc_last valid this cycle
din0  in  DIN0_WIDTH  sample operand
din1  in  DIN1_WIDTH  coefficient operand
acc_first  in  1  sample starts a new frame (accumulator reloads)
acc_last  in  1  sample ends the frame (result emitted)
dout  out  DOUT_WIDTH  frame result
dout_valid  out  1  dout valid
ovf  out  1  result exceeded DOUT range, qualified by dout_valid

Behaviour:
- Reset (reset=0, asynchronous): all pipeline data/sideband regs, accumulator, dout, dout_valid, ovf -> 0. Partial frame discarded. First post-reset frame must start with acc_first.
- Operands extended per SIGNED0/SIGNED1 to DIN0_WIDTH+DIN1_WIDTH+1 bits. Product is exact, then sign-extended (zero-extended if both unsigned) to ACC_WIDTH.
- Multiplier stages 1..NUM_STAGE: product, valid, first and last advance one stage per cycle when ce=1.
- Accumulator stage, on a valid sample with ce=1: acc <= first ? product : acc + product, modulo 2^ACC_WIDTH. Invalid slot: acc holds.
- Output stage, on a valid sample with last=1 and ce=1: r = acc_next >>> SHIFT (logical shift if both operands are unsigned).
  - If r fits DOUT_WIDTH: dout <= r, ovf <= 0.
  - Otherwise, SAT_EN=1: dout <= DOUT max/min per sign of r; SAT_EN=0: dout <= low DOUT_WIDTH bits of r. ovf <= 1 in both cases.
  - dout_valid <= 1.
  - Any other ce=1 cycle: dout_valid <= 0; dout and ovf hold.
- Latency: NUM_STAGE+1 enabled cycles from the input sample with acc_last to dout_valid=1. Throughput is 1 sample per cycle.
- ce=0: all registers hold, including dout_valid. Inputs presented while ce=0 are not captured; upstream holds them.
- acc_first and acc_last together: single-sample frame, dout = product (shift/saturate applied).
- acc_last without a preceding acc_first since the last frame: sum continues from the held acc. This is legal and deterministic.
- acc_first mid-frame: previous partial sum silently dropped.
- Accumulator overflow wraps with no detection. ACC_WIDTH guard bits are sized at instantiation for the maximum tap count.

Decomposition:
- Package fir_mac_pkg: product-width constant function, saturate/narrow function (value, width, signed) returning {result, ovf}, SHIFT-range check.
- Sub-module fir_mul_pipe: signedness-extended multiplier plus NUM_STAGE register chain carrying valid/first/last. fir_mac_pipe adds the accumulator and output stages.

Test Plan:
- Defaults, ce=1: one sample din0=-5, din1=3, first=last=1 -> dout_valid high exactly 3 cycles later, dout=-15, ovf=0.
- Four-sample frame din0=1000,2000,3000,4000; din1=1,-2,3,-4; first on 1st, last on 4th -> single dout_valid pulse, dout=-10000, ovf=0.
- Two samples din0=0x7FFFFFFF, din1=127 -> SAT_EN=1: dout=0x7FFFFFFF, ovf=1. SAT_EN=0: dout=0xFFFFFF02, ovf=1.
- ce low for 3 cycles while a frame is in the multiplier stages -> dout_valid is delayed by exactly 3 cycles and the value matches the ce=1 run. dout_valid stays high while ce is low after assertion.
- SIGNED1=0, din1=0xFF, din0=2, single-sample frame -> dout=510. Same with SIGNED1=1 -> dout=-2.
- Reset asserted mid-frame, asynchronously between clock edges -> dout, dout_valid, ovf = 0 immediately. After release, a new single-sample frame 7x6 -> dout=42 with no residue.

Source files
------------

// File: rtl/fir_mac_pkg.sv
// Shared constants and helpers for the FIR MAC datapath: product sizing,
// result narrowing with saturation/overflow detection, parameter checks.
package fir_mac_pkg;

  localparam int MAX_W = 128;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

  function automatic bit shift_ok(input int shift, input int acc_w);
    return (shift >= 0) && (shift < acc_w);
  endfunction

  // Returns {ovf, result}; the caller keeps the low 'w' bits of result.
  function automatic logic [MAX_W:0] sat_narrow(input logic signed [MAX_W-1:0] v,
                                                input int w, input bit sgn, input bit sat);
    logic signed [MAX_W-1:0] one, hi, lo, res;
    logic                    ovf;
    one = MAX_W'(1);
    if (sgn) begin
      hi = (one <<< (w - 1)) - one;
      lo = -(one <<< (w - 1));
    end else begin
      hi = (one <<< w) - one;
      lo = '0;
    end
    ovf = 1'b0;
    res = v;
    if (v > hi) begin
      ovf = 1'b1;
      if (sat) res = hi;
    end else if (v < lo) begin
      ovf = 1'b1;
      if (sat) res = lo;
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/fir_mul_pipe.sv
// Signedness-extended multiplier followed by NUM_STAGE registers that carry
// the ACC-width product together with its valid/first/last sideband.
module fir_mul_pipe
  import fir_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 8,
  parameter int ACC_WIDTH  = 40,
  parameter int NUM_STAGE  = 2,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_first,
  input  logic                  acc_last,
  output logic [ACC_WIDTH-1:0]  prod,
  output logic                  prod_valid,
  output logic                  prod_first,
  output logic                  prod_last
);

  localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int EW = (PW > ACC_WIDTH) ? PW : ACC_WIDTH;

  logic signed [DIN0_WIDTH:0] a_ext;
  logic signed [DIN1_WIDTH:0] b_ext;
  logic signed [PW-1:0]       full;
  logic [ACC_WIDTH-1:0]       prod_s0;

  logic [ACC_WIDTH-1:0] prod_q [1:NUM_STAGE];
  logic [ACC_WIDTH-1:0] prod_d [1:NUM_STAGE];
  logic [NUM_STAGE:1]   vld_pipe_q, vld_pipe_d;
  logic [NUM_STAGE:1]   first_pipe_q, first_pipe_d;
  logic [NUM_STAGE:1]   last_pipe_q, last_pipe_d;

  // One extra bit per operand makes a signed multiply cover all signedness
  // mixes; the PW-bit product is exact since neither operand can be the
  // most negative value of its extended width.
  always_comb begin
    a_ext   = {(SIGNED0 != 0) & din0[DIN0_WIDTH-1], din0};
    b_ext   = {(SIGNED1 != 0) & din1[DIN1_WIDTH-1], din1};
    full    = PW'(a_ext) * PW'(b_ext);
    prod_s0 = ACC_WIDTH'(EW'(full));
  end

  always_comb begin
    prod_d       = prod_q;
    vld_pipe_d   = vld_pipe_q;
    first_pipe_d = first_pipe_q;
    last_pipe_d  = last_pipe_q;
    if (ce) begin
      prod_d[1]       = prod_s0;
      vld_pipe_d[1]   = in_valid;
      first_pipe_d[1] = acc_first;
      last_pipe_d[1]  = acc_last;
      for (int i = 2; i <= NUM_STAGE; i++) begin
        prod_d[i]       = prod_q[i-1];
        vld_pipe_d[i]   = vld_pipe_q[i-1];
        first_pipe_d[i] = first_pipe_q[i-1];
        last_pipe_d[i]  = last_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= NUM_STAGE; i++) prod_q[i] <= '0;
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
    end else begin
      prod_q       <= prod_d;
      vld_pipe_q   <= vld_pipe_d;
      first_pipe_q <= first_pipe_d;
      last_pipe_q  <= last_pipe_d;
    end
  end

  assign prod       = prod_q[NUM_STAGE];
  assign prod_valid = vld_pipe_q[NUM_STAGE];
  assign prod_first = first_pipe_q[NUM_STAGE];
  assign prod_last  = last_pipe_q[NUM_STAGE];

endmodule

// File: rtl/fir_mac_pipe.sv
// Pipelined FIR multiply-accumulate: multiplier chain, accumulator stage and
// an output stage that shifts, narrows/saturates and emits one result per frame.
module fir_mac_pipe
  import fir_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 8,
  parameter int ACC_WIDTH  = 40,
  parameter int DOUT_WIDTH = 32,
  parameter int NUM_STAGE  = 2,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1,
  parameter int SAT_EN     = 1,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_first,
  input  logic                  acc_last,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  ovf
);

  localparam bit ANY_SIGNED = (SIGNED0 != 0) || (SIGNED1 != 0);

  if (!shift_ok(SHIFT, ACC_WIDTH)) begin : g_bad_shift
    $error("fir_mac_pipe: SHIFT out of range");
  end
  if (NUM_STAGE < 1) begin : g_bad_stage
    $error("fir_mac_pipe: NUM_STAGE must be >= 1");
  end
  if (ACC_WIDTH < DIN0_WIDTH + DIN1_WIDTH) begin : g_bad_acc
    $error("fir_mac_pipe: ACC_WIDTH too narrow");
  end

  logic [ACC_WIDTH-1:0] m_prod;
  logic                 m_valid, m_first, m_last;

  fir_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .NUM_STAGE  (NUM_STAGE),
    .SIGNED0    (SIGNED0),
    .SIGNED1    (SIGNED1)
  ) u_mul (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .in_valid   (in_valid),
    .din0       (din0),
    .din1       (din1),
    .acc_first  (acc_first),
    .acc_last   (acc_last),
    .prod       (m_prod),
    .prod_valid (m_valid),
    .prod_first (m_first),
    .prod_last  (m_last)
  );

  logic [ACC_WIDTH-1:0]        acc_q, acc_d, acc_next;
  logic [DOUT_WIDTH-1:0]       dout_q, dout_d;
  logic                        dout_valid_q, dout_valid_d;
  logic                        ovf_q, ovf_d;
  logic signed [ACC_WIDTH-1:0] r_s;
  logic signed [MAX_W-1:0]     r_ext;
  logic [MAX_W:0]              sat_r;

  always_comb begin
    acc_next = m_first ? m_prod : acc_q + m_prod;
    r_s      = '0;
    if (ANY_SIGNED) begin
      r_s   = $signed(acc_next) >>> SHIFT;
      r_ext = MAX_W'(r_s);
    end else begin
      r_ext = MAX_W'(acc_next >> SHIFT);
    end
    sat_r = sat_narrow(r_ext, DOUT_WIDTH, ANY_SIGNED, SAT_EN != 0);
  end

  // dout_valid is a one-cycle pulse in enabled time; with ce low it holds.
  always_comb begin
    acc_d        = acc_q;
    dout_d       = dout_q;
    ovf_d        = ovf_q;
    dout_valid_d = dout_valid_q;
    if (ce) begin
      dout_valid_d = 1'b0;
      if (m_valid) begin
        acc_d = acc_next;
        if (m_last) begin
          dout_d       = DOUT_WIDTH'(sat_r[MAX_W-1:0]);
          ovf_d        = sat_r[MAX_W];
          dout_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q        <= '0;
      dout_q       <= '0;
      ovf_q        <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      ovf_q        <= ovf_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_fir_mac_pipe.sv
// Directed bench for fir_mac_pipe: saturating, truncating and unsigned-coefficient
// instances share one stimulus stream; expected values are hand-computed.
module tb_fir_mac_pipe;

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, acc_first, acc_last;
  logic [31:0] din0;
  logic [7:0]  din1;

  logic [31:0] s_dout, t_dout, u_dout;
  logic        s_dv, t_dv, u_dv, s_ovf, t_ovf, u_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_mac_pipe u_sat (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_first(acc_first), .acc_last(acc_last), .dout(s_dout), .dout_valid(s_dv), .ovf(s_ovf)
  );

  fir_mac_pipe #(.SAT_EN(0)) u_trn (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_first(acc_first), .acc_last(acc_last), .dout(t_dout), .dout_valid(t_dv), .ovf(t_ovf)
  );

  fir_mac_pipe #(.SIGNED1(0)) u_uns (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_first(acc_first), .acc_last(acc_last), .dout(u_dout), .dout_valid(u_dv), .ovf(u_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [7:0] b,
                       input logic f, input logic l);
    in_valid  = v;
    din0      = a;
    din1      = b;
    acc_first = f;
    acc_last  = l;
  endtask

  initial begin
    reset = 1'b0;
    ce    = 1'b1;
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_dout", s_dout, 32'd0);
    chk("rst_dv", 32'(s_dv), 32'd0);
    chk("rst_ovf", 32'(s_ovf), 32'd0);
    reset = 1'b1;
    tick();

    // single sample -5 * 3, result three edges after capture
    drive(1'b1, 32'hFFFF_FFFB, 8'd3, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    tick();
    chk("t1_dv_early", 32'(s_dv), 32'd0);
    tick();
    chk("t1_dv", 32'(s_dv), 32'd1);
    chk("t1_dout", s_dout, 32'hFFFF_FFF1);
    chk("t1_ovf", 32'(s_ovf), 32'd0);
    tick();
    chk("t1_dv_pulse", 32'(s_dv), 32'd0);

    // four-tap frame: 1000 - 4000 + 9000 - 16000 = -10000
    drive(1'b1, 32'd1000, 8'h01, 1'b1, 1'b0); tick();
    drive(1'b1, 32'd2000, 8'hFE, 1'b0, 1'b0); tick();
    drive(1'b1, 32'd3000, 8'h03, 1'b0, 1'b0); tick();
    drive(1'b1, 32'd4000, 8'hFC, 1'b0, 1'b1); tick();
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    tick();
    chk("t2_dv_early", 32'(s_dv), 32'd0);
    tick();
    chk("t2_dv", 32'(s_dv), 32'd1);
    chk("t2_dout", s_dout, 32'hFFFF_D8F0);
    chk("t2_ovf", 32'(s_ovf), 32'd0);
    chk("t2_trn_dout", t_dout, 32'hFFFF_D8F0);
    tick();
    chk("t2_dv_pulse", 32'(s_dv), 32'd0);

    // 2 * 0x7FFFFFFF * 127 = 0x7E_FFFF_FF02 overflows 32 bits
    drive(1'b1, 32'h7FFF_FFFF, 8'd127, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h7FFF_FFFF, 8'd127, 1'b0, 1'b1); tick();
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("t3_sat_dv", 32'(s_dv), 32'd1);
    chk("t3_sat_dout", s_dout, 32'h7FFF_FFFF);
    chk("t3_sat_ovf", 32'(s_ovf), 32'd1);
    chk("t3_trn_dout", t_dout, 32'hFFFF_FF02);
    chk("t3_trn_ovf", 32'(t_ovf), 32'd1);

    // ce low for three edges while the sample sits in the multiplier
    drive(1'b1, 32'hFFFF_FFFB, 8'd3, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    ce = 1'b0;
    tick();
    chk("t4_dv_stall0", 32'(s_dv), 32'd0);
    tick();
    tick();
    chk("t4_dv_stall2", 32'(s_dv), 32'd0);
    ce = 1'b1;
    tick();
    chk("t4_dv_early", 32'(s_dv), 32'd0);
    tick();
    chk("t4_dv", 32'(s_dv), 32'd1);
    chk("t4_dout", s_dout, 32'hFFFF_FFF1);
    ce = 1'b0;
    tick();
    tick();
    chk("t4_dv_hold", 32'(s_dv), 32'd1);
    chk("t4_dout_hold", s_dout, 32'hFFFF_FFF1);
    ce = 1'b1;
    tick();
    chk("t4_dv_drop", 32'(s_dv), 32'd0);

    // coefficient 0xFF: 255 unsigned, -1 signed
    drive(1'b1, 32'd2, 8'hFF, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("t5_uns_dv", 32'(u_dv), 32'd1);
    chk("t5_uns_dout", u_dout, 32'd510);
    chk("t5_sgn_dout", s_dout, 32'hFFFF_FFFE);

    // asynchronous reset in the middle of a frame
    drive(1'b1, 32'd100, 8'd1, 1'b1, 1'b0); tick();
    drive(1'b1, 32'd50, 8'd1, 1'b0, 1'b0); tick();
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_rst_dout", s_dout, 32'd0);
    chk("t6_rst_dv", 32'(s_dv), 32'd0);
    chk("t6_rst_ovf", 32'(s_ovf), 32'd0);
    chk("t6_rst_uns_dout", u_dout, 32'd0);
    #2;
    reset = 1'b1;
    tick();
    chk("t6_no_residue_dv", 32'(s_dv), 32'd0);
    drive(1'b1, 32'd7, 8'd6, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("t6_dv", 32'(s_dv), 32'd1);
    chk("t6_dout", s_dout, 32'd42);
    chk("t6_ovf", 32'(s_ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
